shared_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register between four requesters. Each requester raises a request, receives a registered one-hot grant, and has its data word loaded into the shared register on the following edge, acknowledged with a one-cycle pulse. The block sits between the lab's requester logic and the shared storage flops, so that no two sources ever drive the register on the same edge.

---
 rtl/shared_reg_arbiter_if.sv | 34 +++
 rtl/shared_reg_arbiter.sv | 120 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the four requesters and the shared-register arbiter.
// Optional clear input guarded by SHARED_REG_CLR_EN.
interface shared_reg_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] wr_data;
`ifdef SHARED_REG_CLR_EN
  logic               clr;
`endif
  logic [3:0]         grant;
  logic [3:0]         ack;
  logic [1:0]         owner;
  logic               busy;
  logic [WIDTH-1:0]   Q;

  // Requester side drives requests and data
  modport master (
`ifdef SHARED_REG_CLR_EN
    output clr,
`endif
    output req, wr_data,
    input  grant, ack, owner, busy, Q
  );

  // Arbiter side
  modport slave (
`ifdef SHARED_REG_CLR_EN
    input  clr,
`endif
    input  req, wr_data,
    output grant, ack, owner, busy, Q
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter giving four requesters exclusive write access to one
// shared WIDTH-bit register. Grant, ack, owner, busy and Q are all registered.
// Optional feature macro: SHARED_REG_CLR_EN adds a synchronous clear of Q
// that overrides (and defers) any arbitrated write.
module shared_reg_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  shared_reg_arbiter_if.slave  bus
);
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [IDX_W-1:0]   pick_c;
  logic [WIDTH-1:0]   data_c [NREQ];

  // Split the flat data bus into one word per requester
  for (genvar i = 0; i < NREQ; i++) begin : g_data
    assign data_c[i] = bus.wr_data[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: first set request starting at ptr, lowest offset wins
  always_comb begin : p_pick
    logic [IDX_W-1:0] cand;
    pick_c = ptr_q;
    cand   = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr_q + IDX_W'(i);
      if (bus.req[cand]) pick_c = cand;
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ack_d   = '0;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = NREQ'(1) << pick_c;
          owner_d = pick_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef SHARED_REG_CLR_EN
        else if (bus.clr) begin
          state_d = GRANT;
        end
`endif
        else begin
          q_d     = data_c[owner_q];
          ack_d   = NREQ'(1) << owner_q;
          ptr_d   = owner_q + IDX_W'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
`ifdef SHARED_REG_CLR_EN
    if (bus.clr) q_d = '0;
`endif
    busy_d = (state_d != IDLE);
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.Q     = q_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (WIDTH=8): stimulus pushes expected
// ack/Q pairs, a negedge monitor pops and compares every ack pulse.
module tb_shared_reg_arbiter;
  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [3:0]       ack;
    logic [WIDTH-1:0] q;
  } exp_t;

  logic Clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  shared_reg_arbiter_if #(.WIDTH(WIDTH)) bus ();

  shared_reg_arbiter #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    bus.wr_data[i*WIDTH +: WIDTH] = v;
  endtask

  // Monitor: every ack pulse must match the head of the scoreboard
  always @(negedge Clk) begin
    if (bus.ack != 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=%b Q=%h expected no ack at %0t",
                 bus.ack, bus.Q, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_value", 32'(bus.ack), 32'(e.ack));
        chk("ack_q", 32'(bus.Q), 32'(e.q));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int cnt [4];
    reset_n     = 1'b0;
    bus.req     = 4'b0000;
    bus.wr_data = '0;
`ifdef SHARED_REG_CLR_EN
    bus.clr     = 1'b0;
`endif
    #2;
    // Reset state
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_ack",   32'(bus.ack),   32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_q",     32'(bus.Q),     32'h0);
    @(negedge Clk);
    reset_n = 1'b1;
    tick(1);

    // Single request from requester 0
    set_data(0, 8'hA5);
    bus.req = 4'b0001;
    exp_q.push_back('{ack: 4'b0001, q: 8'hA5});
    tick(1);
    chk("single_grant", 32'(bus.grant), 32'h1);
    chk("single_busy",  32'(bus.busy),  32'h1);
    chk("single_q_pre", 32'(bus.Q),     32'h0);
    tick(1);
    chk("single_q", 32'(bus.Q), 32'hA5);
    bus.req = 4'b0000;
    tick(1);
    chk("single_release", 32'(bus.grant), 32'h0);
    chk("single_idle",    32'(bus.busy),  32'h0);
    tick(1);

    // Round-robin from a fresh reset, all four requesting
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    set_data(0, 8'h10);
    set_data(1, 8'h20);
    set_data(2, 8'h30);
    set_data(3, 8'h40);
    exp_q.push_back('{ack: 4'b0001, q: 8'h10});
    exp_q.push_back('{ack: 4'b0010, q: 8'h20});
    exp_q.push_back('{ack: 4'b0100, q: 8'h30});
    exp_q.push_back('{ack: 4'b1000, q: 8'h40});
    exp_q.push_back('{ack: 4'b0001, q: 8'h10});
    bus.req = 4'b1111;
    acks = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 60 && acks < 5; c++) begin
      tick(1);
      for (int i = 0; i < 4; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) bus.req[i] = 1'b1;
        end
        if (bus.ack[i]) begin
          acks++;
          bus.req[i] = 1'b0;
          cnt[i] = 3;
        end
      end
    end
    chk("rr_ack_count", 32'(acks), 32'd5);
    bus.req = 4'b0000;
    tick(2);
    chk("rr_idle", 32'(bus.busy), 32'h0);

    // Abort: requester 2 requests for one cycle only
    bus.req = 4'b0100;
    tick(1);
    chk("abort_grant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    tick(1);
    chk("abort_release", 32'(bus.grant), 32'h0);
    chk("abort_busy",    32'(bus.busy),  32'h0);
    chk("abort_q",       32'(bus.Q),     32'h10);
    // ptr still points at requester 1, so 2 wins over 0
    set_data(0, 8'h66);
    set_data(2, 8'h77);
    exp_q.push_back('{ack: 4'b0100, q: 8'h77});
    exp_q.push_back('{ack: 4'b0001, q: 8'h66});
    bus.req = 4'b0101;
    tick(1);
    chk("after_abort_grant", 32'(bus.grant), 32'h4);
    chk("after_abort_owner", 32'(bus.owner), 32'h2);
    tick(1);
    bus.req = 4'b0001;
    tick(1);
    chk("after_abort_rel", 32'(bus.grant), 32'h0);
    tick(1);
    chk("second_grant", 32'(bus.grant), 32'h1);
    chk("second_owner", 32'(bus.owner), 32'h0);
    tick(1);
    bus.req = 4'b0000;
    tick(2);

    // Async reset 3 ns into the GRANT cycle
    set_data(1, 8'h99);
    bus.req = 4'b0010;
    tick(1);
    chk("ar_grant_pre", 32'(bus.grant), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_grant", 32'(bus.grant), 32'h0);
    chk("ar_busy",  32'(bus.busy),  32'h0);
    chk("ar_q",     32'(bus.Q),     32'h0);
    bus.req = 4'b0000;
    #1;
    reset_n = 1'b1;
    tick(3);
    chk("ar_after_q", 32'(bus.Q), 32'h0);

`ifdef SHARED_REG_CLR_EN
    // Clear during requester 1's grant defers the write
    set_data(0, 8'h5A);
    exp_q.push_back('{ack: 4'b0001, q: 8'h5A});
    bus.req = 4'b0001;
    tick(2);
    chk("clr_setup_q", 32'(bus.Q), 32'h5A);
    bus.req = 4'b0000;
    tick(2);
    set_data(1, 8'hC3);
    bus.req = 4'b0010;
    tick(1);
    chk("clr_grant", 32'(bus.grant), 32'h2);
    bus.clr = 1'b1;
    tick(1);
    chk("clr_q0",     32'(bus.Q),     32'h0);
    chk("clr_grant0", 32'(bus.grant), 32'h2);
    tick(1);
    chk("clr_q1",    32'(bus.Q),    32'h0);
    chk("clr_busy1", 32'(bus.busy), 32'h1);
    bus.clr = 1'b0;
    exp_q.push_back('{ack: 4'b0010, q: 8'hC3});
    tick(1);
    chk("clr_write_q", 32'(bus.Q), 32'hC3);
    bus.req = 4'b0000;
    tick(2);
`endif

    // Hold in WAIT: single write, requester 1 waits for release
    set_data(0, 8'hE1);
    set_data(1, 8'hE2);
    exp_q.push_back('{ack: 4'b0001, q: 8'hE1});
    exp_q.push_back('{ack: 4'b0010, q: 8'hE2});
    bus.req = 4'b0001;
    tick(1);
    chk("hold_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0011;
    tick(1);
    chk("hold_q", 32'(bus.Q), 32'hE1);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("hold_grant_wait", 32'(bus.grant), 32'h1);
    end
    bus.req = 4'b0010;
    tick(1);
    chk("hold_release", 32'(bus.grant), 32'h0);
    tick(1);
    chk("hold_next_grant", 32'(bus.grant), 32'h2);
    tick(1);
    chk("hold_next_q", 32'(bus.Q), 32'hE2);
    bus.req = 4'b0000;
    tick(3);

    chk("pending_acks", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
